// File: rtl/timer0_irq_unit.sv
// timer0_irq_unit: TIFR/TIMSK holder and prioritised interrupt requester for timer 0.
// Define TIMER0_TOV_INT_EN to keep the overflow (TOV0/TOIE0) interrupt path.
module timer0_irq_unit #(
  parameter logic [5:0] TIFR_ADDR  = 6'h38,
  parameter logic [5:0] TIMSK_ADDR = 6'h39,
  parameter logic [7:0] VEC_COMP   = 8'h14,
  parameter logic [7:0] VEC_OVF    = 8'h16
) (
  input  logic       sysClock,
  input  logic       nReset,
  input  logic       TIFR_write_enable,
  input  logic [7:0] TIFR_data,
  input  logic [5:0] io_addr,
  input  logic       io_write,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  input  logic       global_ie,
  output logic       int_request,
  output logic [7:0] int_vector,
  input  logic       int_ack
);
`ifdef TIMER0_TOV_INT_EN
  localparam logic [1:0] IMPL = 2'b11;
`else
  localparam logic [1:0] IMPL = 2'b10;
`endif
  typedef enum logic [1:0] {IDLE, REQUEST, CLEAR} state_t;
  state_t state_q, state_d;
  logic [1:0] tifr_q, tifr_d, timsk_q, timsk_d;
  logic       comp_q, comp_d;
  logic [7:0] vec_q, vec_d;
  logic [1:0] pend, set_m, clr_m;
  logic       eligible, src_pend, ack_fire;
  logic       unused_ok;
  assign unused_ok = &{1'b0, TIFR_data[7:2], io_wdata[7:2]};
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      tifr_q  <= 2'b00;
      timsk_q <= 2'b00;
      comp_q  <= 1'b0;
      vec_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
      comp_q  <= comp_d;
      vec_q   <= vec_d;
    end
  end
  // Timer set is OR'ed in after all clears so a coincident event is never lost.
  always_comb begin
    pend     = tifr_q & timsk_q;
    eligible = global_ie & |pend;
    src_pend = comp_q ? pend[1] : pend[0];
    ack_fire = (state_q == REQUEST) & int_ack;
    set_m    = TIFR_write_enable ? TIFR_data[1:0] & IMPL : 2'b00;
    clr_m    = ((io_write && io_addr == TIFR_ADDR) ? io_wdata[1:0] : 2'b00) |
               (ack_fire ? {comp_q, ~comp_q} : 2'b00);
    tifr_d   = ((tifr_q & ~clr_m) | set_m) & IMPL;
    timsk_d  = (io_write && io_addr == TIMSK_ADDR) ? io_wdata[1:0] & IMPL : timsk_q;
    comp_d   = (state_q == IDLE && eligible) ? pend[1] : comp_q;
    vec_d    = (state_q == IDLE && eligible) ? (pend[1] ? VEC_COMP : VEC_OVF) : vec_q;
  end
  always_comb begin
    state_d = state_q == IDLE    ? (eligible ? REQUEST : IDLE) :
              state_q == REQUEST ? (int_ack ? CLEAR : (!src_pend || !global_ie) ? IDLE : REQUEST) :
              IDLE;
  end
  always_comb begin
    int_request = state_q == REQUEST;
    int_vector  = vec_q;
    io_rdata    = io_addr == TIFR_ADDR  ? {6'b0, tifr_q}  :
                  io_addr == TIMSK_ADDR ? {6'b0, timsk_q} : 8'h00;
  end
endmodule

// File: tb/tb_timer0_irq_unit.sv
// tb_timer0_irq_unit: directed scenarios plus randomized traffic against a flag/mask/phase model.
module tb_timer0_irq_unit;
  localparam logic [5:0] TA = 6'h38, MA = 6'h39;
`ifdef TIMER0_TOV_INT_EN
  localparam logic [1:0] IMPL = 2'b11;
`else
  localparam logic [1:0] IMPL = 2'b10;
`endif
  logic sysClock = 0, nReset = 0;
  logic TIFR_write_enable = 0, io_write = 0, global_ie = 0, int_ack = 0;
  logic [7:0] TIFR_data = 0, io_wdata = 0;
  logic [5:0] io_addr = 0;
  logic [7:0] io_rdata, int_vector;
  logic int_request;
  int vecs = 0, errs = 0;
  logic [1:0] m_tifr = 0, m_timsk = 0;
  int m_phase = 0;
  logic m_comp = 0;
  logic [7:0] m_vec = 0;
  timer0_irq_unit dut (
    .sysClock(sysClock), .nReset(nReset), .TIFR_write_enable(TIFR_write_enable),
    .TIFR_data(TIFR_data), .io_addr(io_addr), .io_write(io_write), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .global_ie(global_ie), .int_request(int_request),
    .int_vector(int_vector), .int_ack(int_ack)
  );
  always #5 sysClock = ~sysClock;
  function automatic logic [7:0] exp_rd(input logic [5:0] a);
    return a == TA ? {6'b0, m_tifr} : a == MA ? {6'b0, m_timsk} : 8'h00;
  endfunction
  // Phase 0 = waiting, 1 = requesting, 2 = post-ack gap.
  task automatic cycle(input logic tw, input logic [7:0] td, input logic [5:0] a,
                       input logic wr, input logic [7:0] wd, input logic g, input logic ak);
    logic [1:0] pend, set, clr, n_tifr, n_timsk;
    int n_phase;
    TIFR_write_enable = tw; TIFR_data = td; io_addr = a; io_write = wr; io_wdata = wd;
    global_ie = g; int_ack = ak;
    pend = m_tifr & m_timsk;
    set = tw ? td[1:0] & IMPL : 2'b00;
    clr = (wr && a == TA) ? wd[1:0] : 2'b00;
    if (m_phase == 1 && ak) clr = clr | (m_comp ? 2'b10 : 2'b01);
    n_tifr = ((m_tifr & ~clr) | set) & IMPL;
    n_timsk = (wr && a == MA) ? wd[1:0] & IMPL : m_timsk;
    n_phase = 0;
    if (m_phase == 0 && g && pend != 0) begin
      n_phase = 1; m_comp = pend[1]; m_vec = pend[1] ? 8'h14 : 8'h16;
    end else if (m_phase == 1) begin
      if (ak) n_phase = 2;
      else if (g && (m_comp ? pend[1] : pend[0])) n_phase = 1;
    end
    @(posedge sysClock);
    m_tifr = n_tifr; m_timsk = n_timsk; m_phase = n_phase;
    @(negedge sysClock);
    TIFR_write_enable = 0; io_write = 0; int_ack = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge sysClock);
    io_addr = TA; #1;
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", int_request); end
    vecs++; if (int_vector !== 8'h00) begin errs++; $display("FAIL rst_vec got %h want 00", int_vector); end
    vecs++; if (io_rdata !== 8'h00) begin errs++; $display("FAIL rst_tifr got %h want 00", io_rdata); end
    io_addr = MA; #1;
    vecs++; if (io_rdata !== 8'h00) begin errs++; $display("FAIL rst_timsk got %h want 00", io_rdata); end
    @(negedge sysClock); nReset = 1;
  endtask
  task automatic test_comp_basic;
    cycle(0, 0, MA, 1, 8'h02, 1, 0);
    cycle(1, 8'h02, 0, 0, 0, 1, 0);
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL basic_early got %b want 0", int_request); end
    cycle(0, 0, 0, 0, 0, 1, 0);
    vecs++; if (int_request !== 1'b1) begin errs++; $display("FAIL basic_req got %b want 1", int_request); end
    vecs++; if (int_vector !== 8'h14) begin errs++; $display("FAIL basic_vec got %h want 14", int_vector); end
    cycle(0, 0, 0, 0, 0, 1, 1);
    io_addr = TA; #1;
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL basic_ackreq got %b want 0", int_request); end
    vecs++; if (io_rdata !== 8'h00) begin errs++; $display("FAIL basic_ackflag got %h want 00", io_rdata); end
    cycle(0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic test_both;
    cycle(0, 0, MA, 1, 8'h03, 1, 0);
    cycle(1, 8'h03, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    vecs++; if (int_vector !== 8'h14 || int_request !== 1'b1) begin errs++; $display("FAIL both_first got %b/%h want 1/14", int_request, int_vector); end
    cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
`ifdef TIMER0_TOV_INT_EN
    vecs++; if (int_vector !== 8'h16 || int_request !== 1'b1) begin errs++; $display("FAIL both_second got %b/%h want 1/16", int_request, int_vector); end
    cycle(0, 0, 0, 0, 0, 1, 1);
`else
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL both_noovf got %b want 0", int_request); end
`endif
    io_addr = TA; #1;
    vecs++; if (io_rdata !== 8'h00) begin errs++; $display("FAIL both_tifr got %h want 00", io_rdata); end
    cycle(0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic test_withdraw;
    logic [7:0] b, v;
`ifdef TIMER0_TOV_INT_EN
    b = 8'h01; v = 8'h16;
`else
    b = 8'h02; v = 8'h14;
`endif
    cycle(0, 0, MA, 1, b, 1, 0);
    cycle(1, b, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    vecs++; if (int_request !== 1'b1 || int_vector !== v) begin errs++; $display("FAIL wd_req got %b/%h want 1/%h", int_request, int_vector, v); end
    cycle(0, 0, TA, 1, b, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    io_addr = TA; #1;
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL wd_drop got %b want 0", int_request); end
    vecs++; if (io_rdata !== 8'h00) begin errs++; $display("FAIL wd_tifr got %h want 00", io_rdata); end
  endtask
  task automatic test_set_wins;
    cycle(0, 0, MA, 1, 8'h02, 0, 0);
    cycle(1, 8'h02, 0, 0, 0, 0, 0);
    cycle(1, 8'h02, TA, 1, 8'h02, 0, 0);
    io_addr = TA; #1;
    vecs++; if (io_rdata !== 8'h02) begin errs++; $display("FAIL setwins_sw got %h want 02", io_rdata); end
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(1, 8'h02, 0, 0, 0, 1, 1);
    io_addr = TA; #1;
    vecs++; if (io_rdata !== 8'h02 || int_request !== 1'b0) begin errs++; $display("FAIL setwins_ack got %h/%b want 02/0", io_rdata, int_request); end
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    vecs++; if (int_request !== 1'b1 || int_vector !== 8'h14) begin errs++; $display("FAIL setwins_rereq got %b/%h want 1/14", int_request, int_vector); end
    cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic test_global_ie;
    cycle(0, 0, MA, 1, 8'h03, 0, 0);
    cycle(1, 8'h03, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL gie_off got %b want 0", int_request); end
    cycle(0, 0, 0, 0, 0, 1, 0);
    vecs++; if (int_request !== 1'b1 || int_vector !== 8'h14) begin errs++; $display("FAIL gie_on got %b/%h want 1/14", int_request, int_vector); end
    #2 nReset = 0; io_addr = TA; #1;
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL areset_req got %b want 0", int_request); end
    vecs++; if (io_rdata !== 8'h00) begin errs++; $display("FAIL areset_tifr got %h want 00", io_rdata); end
    m_tifr = 0; m_timsk = 0; m_phase = 0;
    @(negedge sysClock); nReset = 1;
  endtask
  task automatic test_no_tov;
    cycle(1, 8'h01, MA, 1, 8'h03, 1, 0);
    io_addr = TA; #1;
    vecs++; if (io_rdata !== {6'b0, IMPL & 2'b01}) begin errs++; $display("FAIL notov_tifr got %h want %h", io_rdata, {6'b0, IMPL & 2'b01}); end
    io_addr = MA; #1;
    vecs++; if (io_rdata !== {6'b0, IMPL}) begin errs++; $display("FAIL notov_timsk got %h want %h", io_rdata, {6'b0, IMPL}); end
`ifndef TIMER0_TOV_INT_EN
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    vecs++; if (int_request !== 1'b0) begin errs++; $display("FAIL notov_req got %b want 0", int_request); end
`endif
    repeat (4) cycle(0, 0, TA, 1, 8'hff, 0, 0);
  endtask
  task automatic test_random;
    logic [5:0] a;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 3);
      a = r == 0 ? TA : r == 1 ? MA : 6'($urandom);
      cycle($urandom_range(0, 3) == 0, 8'($urandom), a, $urandom_range(0, 3) == 0, 8'($urandom),
            $urandom_range(0, 7) != 0, m_phase == 1 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 7) == 0);
      io_addr = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? TA : MA) : 6'($urandom); #1;
      vecs++; if (int_request !== (m_phase == 1)) begin errs++; $display("FAIL rnd_req[%0d] got %b want %b", i, int_request, m_phase == 1); end
      if (m_phase == 1) begin
        vecs++; if (int_vector !== m_vec) begin errs++; $display("FAIL rnd_vec[%0d] got %h want %h", i, int_vector, m_vec); end
      end
      vecs++; if (io_rdata !== exp_rd(io_addr)) begin errs++; $display("FAIL rnd_rd[%0d] addr %h got %h want %h", i, io_addr, io_rdata, exp_rd(io_addr)); end
    end
  endtask
  initial begin
    test_reset;
    test_comp_basic;
    test_both;
    test_withdraw;
    test_set_wins;
    test_global_ie;
    test_no_tov;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
